// File: rtl/calc_pkg.sv
// Shared encodings for the calculator operand store: FSM state codes,
// operator codes and the largest legal BCD digit.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_OP  = 2'b01,
        S_B   = 2'b10,
        S_RES = 2'b11
    } calc_state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/calc_digit_reg.sv
// One BCD operand: left-shifting digit register with a significant-digit
// counter and a full flag. Loads recompute the count from the loaded value.
module calc_digit_reg #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  shift_i,
    input  logic                  load_i,
    input  logic [3:0]            digit_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   val_o,
    output logic                  full_o
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Position of the most significant non-zero digit, i.e. how many digits count.
    function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
        sig_digits = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) sig_digits = CW'(i + 1);
        end
    endfunction

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            val_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            val_d = load_val_i;
            cnt_d = sig_digits(load_val_i);
        end else if (shift_i && (cnt_q != CW'(DIGITS))) begin
            // Leading zeros into an empty operand do not consume a digit slot.
            if (!((val_q == '0) && (digit_i == 4'd0))) begin
                val_d = W'({val_q, digit_i});
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o  = val_q;
    assign full_o = (cnt_q == CW'(DIGITS));

endmodule

// File: rtl/calc_operand_mem.sv
// Operand/operator store for the calculator datapath with entry FSM.
// Optional result history buffer built only when CALC_MEM_HISTORY_EN is defined.
//
//   state | meaning
//   S_A   | entering operand A (save1)
//   S_OP  | operator latched, operand B still empty
//   S_B   | entering operand B (save2)
//   S_RES | result of equals shown in save1
module calc_operand_mem
    import calc_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int OPW        = 2,
    parameter int HIST_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        num,
    input  logic                              num_valid,
    input  logic [OPW-1:0]                    operator,
    input  logic                              op_valid,
    input  logic                              equ_valid,
    input  logic                              clear_enable,
    input  logic [4*DIGITS-1:0]               res,
    input  logic                              hist_rd,
    input  logic [$clog2(HIST_DEPTH)-1:0]     hist_idx,
    output logic [4*DIGITS-1:0]               save1,
    output logic [4*DIGITS-1:0]               save2,
    output logic [OPW-1:0]                    op_out,
    output logic                              op_set,
    output logic [1:0]                        state_out,
    output logic                              full,
    output logic                              err,
    output logic [4*DIGITS-1:0]               hist_data,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(HIST_DEPTH);
    localparam int HW = $clog2(HIST_DEPTH + 1);

    calc_state_e    state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           op_set_q, op_set_d;
    logic           err_q, err_d;

    logic           clr;
    logic           a_shift, a_load, b_shift, b_load;
    logic [W-1:0]   a_load_val, b_load_val;
    logic           a_full, b_full;
    logic           hist_wr;

    calc_digit_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .shift_i    (a_shift),
        .load_i     (a_load),
        .digit_i    (num),
        .load_val_i (a_load_val),
        .val_o      (save1),
        .full_o     (a_full)
    );

    calc_digit_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .shift_i    (b_shift),
        .load_i     (b_load),
        .digit_i    (num),
        .load_val_i (b_load_val),
        .val_o      (save2),
        .full_o     (b_full)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_set_d   = op_set_q;
        err_d      = err_q;
        clr        = 1'b0;
        a_shift    = 1'b0;
        a_load     = 1'b0;
        a_load_val = '0;
        b_shift    = 1'b0;
        b_load     = 1'b0;
        b_load_val = '0;
        hist_wr    = 1'b0;

        // Strobes are mutually prioritised; the losers in a cycle are dropped.
        if (clear_enable) begin
            clr      = 1'b1;
            state_d  = S_A;
            op_d     = '0;
            op_set_d = 1'b0;
            err_d    = 1'b0;
        end else if (equ_valid) begin
            if (state_q == S_B) begin
                a_load     = 1'b1;
                a_load_val = res;
                b_load     = 1'b1;
                op_set_d   = 1'b0;
                state_d    = S_RES;
                hist_wr    = 1'b1;
            end
        end else if (op_valid) begin
            op_d     = operator;
            op_set_d = 1'b1;
            state_d  = S_OP;
            // Chained operator: fold the pending result into A and restart B.
            if (state_q == S_B) begin
                a_load     = 1'b1;
                a_load_val = res;
                b_load     = 1'b1;
            end
        end else if (num_valid) begin
            if (num > BCD_MAX) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    S_A:   a_shift = 1'b1;
                    S_OP: begin
                        b_load     = 1'b1;
                        b_load_val = W'(num);
                        state_d    = S_B;
                    end
                    S_B:   b_shift = 1'b1;
                    S_RES: begin
                        a_load     = 1'b1;
                        a_load_val = W'(num);
                        state_d    = S_A;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            op_q     <= '0;
            op_set_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            op_set_q <= op_set_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        full = 1'b0;
        case (state_q)
            S_A, S_RES: full = a_full;
            S_B:        full = b_full;
            default:    full = 1'b0;
        endcase
    end

    assign op_out    = op_q;
    assign op_set    = op_set_q;
    assign err       = err_q;
    assign state_out = state_q;

`ifdef CALC_MEM_HISTORY_EN
    logic [W-1:0]  hist_mem_q [HIST_DEPTH];
    logic [IW-1:0] wr_ptr_q;
    logic [HW-1:0] hcnt_q;
    logic [W-1:0]  hdata_q;
    logic [IW-1:0] rd_ptr;

    // Newest entry sits just behind the write pointer.
    assign rd_ptr = wr_ptr_q - IW'(1) - hist_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            hcnt_q   <= '0;
            hdata_q  <= '0;
        end else begin
            if (hist_wr) begin
                hist_mem_q[wr_ptr_q] <= res;
                wr_ptr_q             <= wr_ptr_q + IW'(1);
                if (hcnt_q != HW'(HIST_DEPTH)) hcnt_q <= hcnt_q + HW'(1);
            end
            if (hist_rd) begin
                hdata_q <= (HW'(hist_idx) < hcnt_q) ? hist_mem_q[rd_ptr] : '0;
            end
        end
    end

    assign hist_data  = hdata_q;
    assign hist_count = hcnt_q;
`else
    logic unused_hist;
    assign unused_hist = ^{hist_rd, hist_idx, hist_wr};
    assign hist_data   = '0;
    assign hist_count  = '0;
`endif

endmodule

// File: tb/tb_calc_operand_mem.sv
// Scoreboard bench for calc_operand_mem: directed events push expected
// snapshots, a negedge monitor pops and compares them.
module tb_calc_operand_mem;
    import calc_pkg::*;

`ifdef CALC_MEM_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  num;
    logic        num_valid;
    logic [1:0]  operator;
    logic        op_valid;
    logic        equ_valid;
    logic        clear_enable;
    logic [15:0] res;
    logic        hist_rd;
    logic [1:0]  hist_idx;
    logic [15:0] save1, save2;
    logic [1:0]  op_out;
    logic        op_set;
    logic [1:0]  state_out;
    logic        full;
    logic        err;
    logic [15:0] hist_data;
    logic [2:0]  hist_count;

    calc_operand_mem #(.DIGITS(4), .OPW(2), .HIST_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .num          (num),
        .num_valid    (num_valid),
        .operator     (operator),
        .op_valid     (op_valid),
        .equ_valid    (equ_valid),
        .clear_enable (clear_enable),
        .res          (res),
        .hist_rd      (hist_rd),
        .hist_idx     (hist_idx),
        .save1        (save1),
        .save2        (save2),
        .op_out       (op_out),
        .op_set       (op_set),
        .state_out    (state_out),
        .full         (full),
        .err          (err),
        .hist_data    (hist_data),
        .hist_count   (hist_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [1:0]  op;
        logic        opset;
        logic [1:0]  st;
        logic        fl;
        logic        er;
        logic [15:0] hd;
        logic [2:0]  hc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          checks   = 0;
    int          failures = 0;
    logic        chk      = 1'b0;

    logic [15:0] x_s1, x_s2, x_hd;
    logic [1:0]  x_op, x_st;
    logic        x_opset, x_fl, x_er;
    logic [2:0]  x_hc;

    task automatic cmp(input string nm, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow actual=0 required=1");
            end else begin
                cur = sb_q.pop_front();
                cmp(cur.nm, "save1",      save1,                cur.s1);
                cmp(cur.nm, "save2",      save2,                cur.s2);
                cmp(cur.nm, "op_out",     16'(op_out),          16'(cur.op));
                cmp(cur.nm, "op_set",     16'(op_set),          16'(cur.opset));
                cmp(cur.nm, "state",      16'(state_out),       16'(cur.st));
                cmp(cur.nm, "full",       16'(full),            16'(cur.fl));
                cmp(cur.nm, "err",        16'(err),             16'(cur.er));
                cmp(cur.nm, "hist_data",  hist_data,            cur.hd);
                cmp(cur.nm, "hist_count", 16'(hist_count),      16'(cur.hc));
            end
        end
    end

    task automatic idle();
        rst = 1'b0; num_valid = 1'b0; op_valid = 1'b0; equ_valid = 1'b0;
        clear_enable = 1'b0; hist_rd = 1'b0;
    endtask

    task automatic set_exp(input logic [15:0] s1, input logic [15:0] s2, input logic [1:0] op,
                           input logic opset, input logic [1:0] st, input logic fl, input logic er);
        x_s1 = s1; x_s2 = s2; x_op = op; x_opset = opset; x_st = st; x_fl = fl; x_er = er;
    endtask

    // Inputs are already driven; let the DUT sample them, then queue the expectation.
    task automatic tick(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        idle();
        e.nm = nm; e.s1 = x_s1; e.s2 = x_s2; e.op = x_op; e.opset = x_opset;
        e.st = x_st; e.fl = x_fl; e.er = x_er; e.hd = x_hd; e.hc = x_hc;
        sb_q.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic dig(input logic [3:0] n, input string nm);
        num = n; num_valid = 1'b1; tick(nm);
    endtask

    task automatic opr(input logic [1:0] o, input string nm);
        operator = o; op_valid = 1'b1; tick(nm);
    endtask

    task automatic equ(input logic [15:0] r, input string nm);
        res = r; equ_valid = 1'b1; tick(nm);
    endtask

    task automatic rd(input logic [1:0] idx, input string nm);
        hist_idx = idx; hist_rd = 1'b1; tick(nm);
    endtask

    task automatic do_reset(input string nm);
        set_exp(16'h0, 16'h0, 2'd0, 1'b0, S_A, 1'b0, 1'b0);
        x_hd = 16'h0; x_hc = 3'd0;
        rst = 1'b1; tick(nm);
    endtask

    initial begin
        logic [15:0] prev;
        idle();
        num = 4'd0; operator = 2'd0; res = 16'h0; hist_idx = 2'd0;
        x_hd = 16'h0; x_hc = 3'd0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // Fill A, then overflow digit is ignored.
        set_exp(16'h0001, 0, 0, 0, S_A, 0, 0); dig(4'd1, "a_1");
        set_exp(16'h0012, 0, 0, 0, S_A, 0, 0); dig(4'd2, "a_12");
        set_exp(16'h0123, 0, 0, 0, S_A, 0, 0); dig(4'd3, "a_123");
        set_exp(16'h1234, 0, 0, 0, S_A, 1, 0); dig(4'd4, "a_full");
        set_exp(16'h1234, 0, 0, 0, S_A, 1, 0); dig(4'd5, "a_ignore5");

        set_exp(16'h0, 0, 0, 0, S_A, 0, 0); clear_enable = 1'b1; tick("clear1");

        // Leading zeros, bad digit, then count proves only one slot was used.
        set_exp(16'h0000, 0, 0, 0, S_A, 0, 0); dig(4'd0, "lz_0");
        set_exp(16'h0000, 0, 0, 0, S_A, 0, 0); dig(4'd0, "lz_00");
        set_exp(16'h0007, 0, 0, 0, S_A, 0, 0); dig(4'd7, "lz_7");
        set_exp(16'h0007, 0, 0, 0, S_A, 0, 1); dig(4'hC, "bad_digit");
        set_exp(16'h0071, 0, 0, 0, S_A, 0, 1); dig(4'd1, "lz_71");
        set_exp(16'h0712, 0, 0, 0, S_A, 0, 1); dig(4'd2, "lz_712");
        set_exp(16'h7123, 0, 0, 0, S_A, 1, 1); dig(4'd3, "lz_full");
        set_exp(16'h0, 0, 0, 0, S_A, 0, 0); clear_enable = 1'b1; tick("clear2");

        // 12 * 3 = 36
        set_exp(16'h0001, 0, 0, 0, S_A, 0, 0); dig(4'd1, "m_1");
        set_exp(16'h0012, 0, 0, 0, S_A, 0, 0); dig(4'd2, "m_12");
        set_exp(16'h0012, 0, 2, 1, S_OP, 0, 0); opr(2'd2, "m_op");
        set_exp(16'h0012, 16'h3, 2, 1, S_B, 0, 0); dig(4'd3, "m_b3");
        x_hc = HIST ? 3'd1 : 3'd0;
        set_exp(16'h0036, 0, 2, 0, S_RES, 0, 0); equ(16'h0036, "m_equ");

        // New entry from result, then chain 5 + 4 - ...
        set_exp(16'h0005, 0, 2, 0, S_A, 0, 0); dig(4'd5, "c_5");
        set_exp(16'h0005, 0, 0, 1, S_OP, 0, 0); opr(2'd0, "c_add");
        set_exp(16'h0005, 16'h4, 0, 1, S_B, 0, 0); dig(4'd4, "c_4");
        set_exp(16'h0009, 0, 1, 1, S_OP, 0, 0); res = 16'h0009; opr(2'd1, "c_chain");

        // Fill B to full.
        set_exp(16'h0009, 16'h0009, 1, 1, S_B, 0, 0); dig(4'd9, "b_9");
        set_exp(16'h0009, 16'h0098, 1, 1, S_B, 0, 0); dig(4'd8, "b_98");
        set_exp(16'h0009, 16'h0987, 1, 1, S_B, 0, 0); dig(4'd7, "b_987");
        set_exp(16'h0009, 16'h9876, 1, 1, S_B, 1, 0); dig(4'd6, "b_full");
        set_exp(16'h0009, 16'h9876, 1, 1, S_B, 1, 0); dig(4'd5, "b_ignore5");

        // equ beats num in the same cycle; four significant result digits -> full.
        x_hc = HIST ? 3'd2 : 3'd0;
        set_exp(16'h1234, 0, 1, 0, S_RES, 1, 0);
        num = 4'd3; num_valid = 1'b1; res = 16'h1234; equ_valid = 1'b1; tick("equ_over_num");

        set_exp(16'h1234, 0, 3, 1, S_OP, 0, 0); opr(2'd3, "res_op");
        set_exp(16'h1234, 0, 3, 1, S_OP, 0, 0); equ(16'hFFFF, "equ_ign_op");
        set_exp(16'h1234, 0, 3, 1, S_B, 0, 0); dig(4'd0, "b0_first");
        set_exp(16'h1234, 0, 3, 1, S_B, 0, 0); dig(4'd0, "b0_lead");
        set_exp(16'h1234, 16'h5, 3, 1, S_B, 0, 0); dig(4'd5, "b_5");

        // rst mid-entry wins over a digit strobe.
        num = 4'd7; num_valid = 1'b1;
        do_reset("rst_mid_b");

        // op beats num in the same cycle.
        set_exp(16'h0004, 0, 0, 0, S_A, 0, 0); dig(4'd4, "p_4");
        set_exp(16'h0004, 0, 1, 1, S_OP, 0, 0);
        num = 4'd7; num_valid = 1'b1; operator = 2'd1; op_valid = 1'b1; tick("op_over_num");

        // History: five commits with res 1..5.
        do_reset("rst_hist");
        prev = 16'h0;
        for (int k = 1; k <= 5; k++) begin
            set_exp(prev, 0, 0, 1, S_OP, 0, 0); opr(2'd0, "h_op");
            set_exp(prev, 16'h1, 0, 1, S_B, 0, 0); dig(4'd1, "h_dig");
            x_hc = HIST ? 3'((k > 4) ? 4 : k) : 3'd0;
            set_exp(16'(k), 0, 0, 0, S_RES, 0, 0); equ(16'(k), "h_equ");
            prev = 16'(k);
            if (k == 2) begin
                x_hd = HIST ? 16'h1 : 16'h0; rd(2'd1, "h_rd1_of2");
                x_hd = 16'h0;                rd(2'd3, "h_rd_oob");
            end
        end
        x_hd = HIST ? 16'h5 : 16'h0; rd(2'd0, "h_rd_newest");
        x_hd = HIST ? 16'h2 : 16'h0; rd(2'd3, "h_rd_oldest");
        x_hd = HIST ? 16'h4 : 16'h0; rd(2'd1, "h_rd_idx1");

        // Functional clear keeps history.
        set_exp(16'h0, 0, 0, 0, S_A, 0, 0); clear_enable = 1'b1; tick("clear_keeps_hist");
        do_reset("rst_final");

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_operand_mem.md
Name: calc_operand_mem

Overview:
Parametrised operand/operator store for the calculator datapath, successor to the fixed 4-digit save1/save2 memory. It accumulates BCD digits for operand A and operand B, holds the pending operator, and captures the ALU result on equals. It supports chained operations and starting a new entry from a result. It sits between the keypad decoder (num/operator strobes) and the ALU/display.

Parameters:
DIGITS, 4, number of BCD digits per operand; operand width W = 4*DIGITS
OPW, 2, operator code width
HIST_DEPTH, 4, result-history entries (used only with CALC_MEM_HISTORY_EN); power of two, >=2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
num  in  4  BCD digit from keypad decoder
num_valid  in  1  one-cycle digit strobe
operator  in  OPW  operator code
op_valid  in  1  one-cycle operator strobe
equ_valid  in  1  one-cycle equals strobe
clear_enable  in  1  functional clear (same effect as rst, except it keeps history)
res  in  W  ALU result, combinational from save1/save2/op_out
hist_rd  in  1  history read strobe
hist_idx  in  clog2(HIST_DEPTH)  0 = newest entry
save1  out  W  operand A / displayed result
save2  out  W  operand B
op_out  out  OPW  latched operator
op_set  out  1  operator latched and pending
state_out  out  2  FSM state code
full  out  1  active operand holds DIGITS significant digits
err  out  1  sticky; a non-BCD digit (>9) was received
hist_data  out  W  registered history read data
hist_count  out  clog2(HIST_DEPTH+1)  valid history entries

Behaviour:
- Reset/clear values: save1=0, save2=0, op_out=0, op_set=0, err=0, full=0, state=S_A(00), digit counters=0. hist_data and hist_count are cleared by rst only.
- Event priority in one cycle: rst > clear_enable > equ_valid > op_valid > num_valid. Lower-priority strobes in the same cycle are dropped.
- All outputs are registered. An event is visible on the cycle after its strobe.
- Digit shift: operand <= {operand[W-5:0], num}, count++. A leading zero (operand==0 and num==0) leaves count unchanged. When count==DIGITS, further digits are ignored and full=1.
- A digit >9 sets err and is otherwise ignored.
- States: S_A=00 (entering A), S_OP=01 (operator pending, B empty), S_B=10 (entering B), S_RES=11 (result shown).
- S_A: num -> shift save1. op -> op_out<=operator, op_set=1, go to S_OP. equ is ignored.
- S_OP: num -> save2<=num, cntB=(num!=0), go to S_B. op -> op_out replaced. equ is ignored.
- S_B: num -> shift save2. equ -> save1<=res, save2<=0, op_set=0, cntA=significant digits of res, go to S_RES. op (chain) -> save1<=res, save2<=0, op_out<=operator, go to S_OP.
- S_RES: num -> save1<=num, cntA=(num!=0), go to S_A. op -> op_out<=operator, op_set=1, go to S_OP. equ is ignored.
- full reflects save1's count in S_A and S_RES, and save2's count in S_OP and S_B (0 in S_OP).
- res is sampled only in the equ/chain cycle. No overflow detection is done here; res is truncated to W by the ALU.

Optional Feature:
CALC_MEM_HISTORY_EN
- When defined: every equ commit writes res into a HIST_DEPTH circular buffer.
  - Write pointer wraps; the oldest entry is overwritten.
  - hist_count saturates at HIST_DEPTH.
  - hist_rd -> hist_data = entry hist_idx back from newest, 1-cycle latency.
  - hist_idx >= hist_count returns 0.
- When not defined: ports remain, the buffer is not built, hist_data=0 and hist_count=0 permanently.

Decomposition:
- Package calc_pkg: state encodings S_A/S_OP/S_B/S_RES, operator codes (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3), BCD_MAX=9.
- Sub-module calc_digit_reg: one operand shift register with its digit counter and full flag, instantiated twice (A and B).
- FSM and history logic live in the top level.

Test Plan:
- rst; digits 1,2,3,4 -> save1=0x1234, full=1; then digit 5 -> save1 unchanged 0x1234.
- digits 0,0,7 -> save1=0x0007, count=1, full=0; digit 0xC -> err=1, save1 unchanged; clear_enable -> err=0, all outputs 0, state=00.
- 12, op=2, 3, equ with res=0x0036 -> op_out=2, save2=0x0003, then save1=0x0036, save2=0, state=11.
- Chain: 5, op=0, 4, op=1 with res=0x0009 -> save1=0x0009, save2=0, op_out=1, state=01.
- Same-cycle equ_valid and num_valid in S_B -> only equ takes effect. rst asserted mid-entry in S_B -> all reset values next cycle.
- With CALC_MEM_HISTORY_EN, HIST_DEPTH=4: five equ commits with res 1..5 -> hist_count=4; hist_idx=0 -> 5; hist_idx=3 -> 2, one cycle after hist_rd.
